// File: rtl/gsim_sequencer.sv
// Gauss-Seidel control sequencer: b-vector load count, row issue for ITER sweeps, LAT-deep write-back tagging.
// Latency: row issue starts the cycle after sample N-1; write-back follows each issue by exactly LAT cycles.
// No backpressure: issues are back-to-back; in_en during RUN/DRAIN aborts the run and restarts the load.
module gsim_sequencer #(
    parameter int N    = 16,
    parameter int ITER = 50,
    parameter int LAT  = 1,
    localparam int IW  = $clog2(N),
    localparam int PW  = $clog2(ITER + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    output logic          b_wr_en,
    output logic [IW-1:0] b_wr_idx,
    output logic          issue_valid,
    output logic [IW-1:0] issue_idx,
    output logic [5:0]    tap_mask,
    output logic [PW-1:0] pass_cnt,
    output logic          wb_en,
    output logic [IW-1:0] wb_idx,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [IW-1:0] ROW_LAST  = IW'(N - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(ITER - 1);

    state_t        state, state_d;
    logic [IW-1:0] load_cnt, load_d;
    logic [IW-1:0] row, row_d;
    logic [PW-1:0] pass, pass_d;
    logic          flush;
    logic          drain_empty;

    logic [LAT-1:0] dl_vld;
    logic [IW-1:0]  dl_idx  [LAT];
    logic [PW-1:0]  dl_pass [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            load_cnt <= '0;
            row      <= '0;
            pass     <= '0;
        end else begin
            state    <= state_d;
            load_cnt <= load_d;
            row      <= row_d;
            pass     <= pass_d;
        end
    end

    // Only the output stage may still hold a valid entry when DRAIN hands over to DONE.
    always_comb begin
        drain_empty = 1'b1;
        for (int k = 0; k < LAT - 1; k++) begin
            if (dl_vld[k]) drain_empty = 1'b0;
        end
    end

    always_comb begin
        state_d     = state;
        load_d      = load_cnt;
        row_d       = row;
        pass_d      = pass;
        flush       = 1'b0;
        b_wr_en     = 1'b0;
        b_wr_idx    = '0;
        issue_valid = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (in_en) begin
                    b_wr_en = 1'b1;
                    load_d  = IW'(1);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                b_wr_en  = in_en;
                b_wr_idx = load_cnt;
                if (in_en) begin
                    if (load_cnt == ROW_LAST) begin
                        load_d  = '0;
                        row_d   = '0;
                        pass_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        load_d = load_cnt + IW'(1);
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                if (in_en) begin
                    // Abort: this cycle is sample 0 of a fresh load; nothing in flight survives.
                    b_wr_en = 1'b1;
                    flush   = 1'b1;
                    load_d  = IW'(1);
                    row_d   = '0;
                    pass_d  = '0;
                    state_d = S_LOAD;
                end else if (state == S_RUN) begin
                    issue_valid = 1'b1;
                    if (row == ROW_LAST) begin
                        row_d = '0;
                        if (pass == PASS_LAST) begin
                            pass_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            pass_d = pass + PW'(1);
                        end
                    end else begin
                        row_d = row + IW'(1);
                    end
                end else if (drain_empty) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign issue_idx = issue_valid ? row  : '0;
    assign pass_cnt  = issue_valid ? pass : '0;

    always_comb begin
        tap_mask = '0;
        if (issue_valid) begin
            tap_mask[0] = (issue_idx >= IW'(1));
            tap_mask[1] = (issue_idx <= IW'(N - 2));
            tap_mask[2] = (issue_idx >= IW'(2));
            tap_mask[3] = (issue_idx <= IW'(N - 3));
            tap_mask[4] = (issue_idx >= IW'(3));
            tap_mask[5] = (issue_idx <= IW'(N - 4));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                dl_idx[k]  <= '0;
                dl_pass[k] <= '0;
            end
        end else if (flush) begin
            dl_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                dl_idx[k]  <= '0;
                dl_pass[k] <= '0;
            end
        end else begin
            dl_vld[0]  <= issue_valid;
            dl_idx[0]  <= issue_idx;
            dl_pass[0] <= pass_cnt;
            for (int k = 1; k < LAT; k++) begin
                dl_vld[k]  <= dl_vld[k-1];
                dl_idx[k]  <= dl_idx[k-1];
                dl_pass[k] <= dl_pass[k-1];
            end
        end
    end

    assign wb_en     = dl_vld[LAT-1];
    assign wb_idx    = dl_idx[LAT-1];
    assign out_valid = wb_en && (dl_pass[LAT-1] == PASS_LAST);
    assign out_idx   = wb_idx;

endmodule
